// File: rtl/rotator_sequencer.sv
// -----------------------------------------------------------------------------
// rotator_sequencer
//
// Command-level controller for one loadable left/right rotator register.
// A requester hands over (data, amount, direction) on a valid/ready command
// port. This block:
//   1. loads the word into the rotator,
//   2. steps the rotator once per clock until the requested rotation is done,
//   3. presents the rotator's output on a valid/ready result port.
// The rotator shares clk and rst_n with this block. Only one command is in
// flight at a time.
//
// Parameters
//   WIDTH     rotator data width (power of two, >= 4)
//   AMT_W     width of the requested rotate amount (>= $clog2(WIDTH))
//   SHORTEST  1: rotate the opposite way when that needs fewer steps
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake; cmd_ready is high only in IDLE
//   cmd_data          word to rotate
//   cmd_amt           requested amount; only its low $clog2(WIDTH) bits matter
//   cmd_dir           0 = rotate left, 1 = rotate right
//   res_valid/ready   result handshake; res_valid is high only in DONE
//   res_data          rotated word (follows rot_data_out)
//   busy              high in any state other than IDLE
//   rot_enable/load/dir/data_in   drive the rotator's control and data pins
//   rot_data_out      rotator's current contents
// -----------------------------------------------------------------------------
module rotator_sequencer #(
  parameter int WIDTH    = 8,
  parameter int AMT_W    = 8,
  parameter bit SHORTEST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_dir,

  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,

  output logic             busy,

  output logic             rot_enable,
  output logic             rot_load,
  output logic             rot_dir,
  output logic [WIDTH-1:0] rot_data_in,
  input  logic [WIDTH-1:0] rot_data_out
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam logic [LOG2W-1:0] CNT_ONE  = LOG2W'(1);
  localparam logic [LOG2W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROTATE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;   // captured word, driven onto rot_data_in
  logic [LOG2W-1:0] cnt_q;    // remaining single-bit rotate steps
  logic             dir_q;    // captured (possibly inverted) direction

  // Step count and direction derived from the incoming command.
  logic [LOG2W-1:0] eff_amt;
  logic [LOG2W-1:0] steps_d;
  logic             step_dir_d;

  // ---------------------------------------------------------------------------
  // Command decode: amount modulo WIDTH is just its low bits. With SHORTEST,
  // an amount past the half-way point is cheaper the other way round; exactly
  // half keeps the requested direction.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    eff_amt    = cmd_amt[LOG2W-1:0];
    steps_d    = eff_amt;
    step_dir_d = cmd_dir;
    if (SHORTEST && (int'(eff_amt) > WIDTH / 2)) begin
      steps_d    = LOG2W'(WIDTH - int'(eff_amt));
      step_dir_d = ~cmd_dir;
    end
  end

  // The amount bits above the modulo are intentionally ignored.
  if (AMT_W > LOG2W) begin : g_amt_hi
    logic unused_amt_hi;
    assign unused_amt_hi = ^cmd_amt[AMT_W-1:LOG2W];
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM.
  // The count holds k from the accept edge onward, so it is already loaded
  // with k while in LOAD. In ROTATE, the edge that sees cnt_q == 1 is the last
  // rotate edge, which gives exactly k rotate edges in total.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            data_q  <= cmd_data;
            cnt_q   <= steps_d;
            dir_q   <= step_dir_d;
            state_q <= LOAD;
          end
        end

        LOAD: begin
          state_q <= (cnt_q != CNT_ZERO) ? ROTATE : DONE;
        end

        ROTATE: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= DONE;
          end
        end

        DONE: begin
          if (res_ready) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. rot_dir and rot_data_in follow the captured registers in
  // every state. Outside ROTATE, rot_load or a low rot_enable dominates, so
  // the rotator ignores rot_dir there.
  // The rotator is disabled in DONE, so res_data is stable while the consumer
  // stalls.
  // ---------------------------------------------------------------------------
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE);
  assign res_data    = rot_data_out;
  assign rot_enable  = (state_q == LOAD) || (state_q == ROTATE);
  assign rot_load    = (state_q == LOAD);
  assign rot_dir     = dir_q;
  assign rot_data_in = data_q;

endmodule
